universal_register_ff: RTL

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with Q and complementary QN outputs.
- The active clock edge is selectable: negative edge by default, positive as an option.
- Supports hold, shift, rotate, parallel-load, clear and invert modes.
- A built-in shift counter pulses Done each time a full word has been shifted, so the block works as a serial/parallel converter in datapath and serial-link exercises.

---
 rtl/universal_register_ff.sv | 107 ++++++++++
 1 files changed

// File: rtl/universal_register_ff.sv
// WIDTH-bit universal register with selectable active clock edge, shift/rotate/load/clear/invert
// modes and a shift counter that pulses Done once per full word shifted.
module universal_register_ff #(
    parameter int unsigned      WIDTH     = 8,
    parameter bit               NEG_EDGE  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     CW        = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             Ck,
    input  logic             Rst,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             SerOutR,
    output logic             SerOutL,
    output logic             Done,
    output logic [CW-1:0]    Count
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q, done_d;
    logic             shift;

    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        done_d  = 1'b0;
        shift   = 1'b0;
        case (Mode)
            3'b000: q_d = q_q;
            3'b001: begin
                q_d   = {SerIn, q_q[WIDTH-1:1]};
                shift = 1'b1;
            end
            3'b010: begin
                q_d   = {q_q[WIDTH-2:0], SerIn};
                shift = 1'b1;
            end
            3'b011: begin
                q_d   = {q_q[0], q_q[WIDTH-1:1]};
                shift = 1'b1;
            end
            3'b100: begin
                q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                shift = 1'b1;
            end
            3'b101: begin
                q_d     = D;
                count_d = '0;
            end
            3'b110: begin
                q_d     = '0;
                count_d = '0;
            end
            3'b111: q_d = ~q_q;
            // An unknown mode must not be masked into a legal operation
            default: q_d = {WIDTH{1'bx}};
        endcase
        if (shift) begin
            if (count_q == LAST) begin
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge Ck) begin
            if (Rst) begin
                q_q     <= RESET_VAL;
                count_q <= '0;
                done_q  <= 1'b0;
            end else begin
                q_q     <= q_d;
                count_q <= count_d;
                done_q  <= done_d;
            end
        end
    end else begin : g_pos
        always_ff @(posedge Ck) begin
            if (Rst) begin
                q_q     <= RESET_VAL;
                count_q <= '0;
                done_q  <= 1'b0;
            end else begin
                q_q     <= q_d;
                count_q <= count_d;
                done_q  <= done_d;
            end
        end
    end

    assign Q       = q_q;
    assign QN      = ~q_q;
    assign SerOutR = q_q[0];
    assign SerOutL = q_q[WIDTH-1];
    assign Done    = done_q;
    assign Count   = count_q;

endmodule
